// File: rtl/config_frame_loader_pkg.sv
// -----------------------------------------------------------------------------
// kfpga_config_pkg
// Shared definitions for the tile configuration loader:
//   cfg_state_t      - loader FSM state (EMPTY / PARTIAL / FULL)
//   clog2()          - constant ceiling-log2 used to size the chunk counter
//   *_CONFIG_WIDTH   - default configuration frame width per tile flavour
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package kfpga_config_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } cfg_state_t;

   // Logic tile configuration bits; other flavours listed for instantiation.
   localparam int CLB_CONFIG_WIDTH = 524;
   localparam int IOB_CONFIG_WIDTH = 64;

   // Smallest r with 2**r >= value (clog2(1) = 0).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/config_frame_loader_if.sv
// -----------------------------------------------------------------------------
// config_frame_loader_if
// Bundles the configuration port of one tile loader.
//   Inputs to the loader : config_enable, config_in, config_commit, config_clear
//   Outputs of the loader: config_out, config_data, config_count, config_ready,
//                          config_loaded, config_error, config_state (debug)
// Handshake: there is no back-pressure. A chunk is consumed on every rising
// edge where config_enable=1; a commit is acted on only when config_ready=1,
// otherwise it raises the sticky config_error. config_clear wins over both.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface config_frame_loader_if
   import kfpga_config_pkg::*;
#(
   parameter int CONFIG_WIDTH = CLB_CONFIG_WIDTH,
   parameter int CHUNK_WIDTH  = 1
);
   localparam int FRAMES      = CONFIG_WIDTH / CHUNK_WIDTH;
   localparam int COUNT_WIDTH = clog2(FRAMES + 1);

   logic                    config_enable;
   logic [CHUNK_WIDTH-1:0]  config_in;
   logic                    config_commit;
   logic                    config_clear;
   logic [CHUNK_WIDTH-1:0]  config_out;
   logic [CONFIG_WIDTH-1:0] config_data;
   logic [COUNT_WIDTH-1:0]  config_count;
   logic                    config_ready;
   logic                    config_loaded;
   logic                    config_error;
   cfg_state_t              config_state;

   modport master (
      output config_enable, config_in, config_commit, config_clear,
      input  config_out, config_data, config_count, config_ready,
             config_loaded, config_error, config_state
   );

   modport slave (
      input  config_enable, config_in, config_commit, config_clear,
      output config_out, config_data, config_count, config_ready,
             config_loaded, config_error, config_state
   );

endinterface

// File: rtl/config_frame_loader_shift_chain.sv
// -----------------------------------------------------------------------------
// config_shift_chain
// Shadow shift register of CONFIG_WIDTH bits, CHUNK_WIDTH bits per shift.
//   i_clk, i_rst_n : configuration clock, async active-low reset
//   i_clear        : synchronous clear (wins over i_enable)
//   i_enable       : shift i_chunk in at the LSB end this cycle
//   i_chunk        : incoming chunk
//   o_shadow       : whole shadow register
//   o_chunk        : top chunk, combinational, feeds the next tile
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module config_shift_chain
   import kfpga_config_pkg::*;
#(
   parameter int CONFIG_WIDTH = CLB_CONFIG_WIDTH,
   parameter int CHUNK_WIDTH  = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_clear,
   input  logic                    i_enable,
   input  logic [CHUNK_WIDTH-1:0]  i_chunk,
   output logic [CONFIG_WIDTH-1:0] o_shadow,
   output logic [CHUNK_WIDTH-1:0]  o_chunk
);

   logic [CONFIG_WIDTH-1:0] r_shadow;
   logic [CONFIG_WIDTH-1:0] w_shifted;

   // A single-chunk frame has no retained bits, so the slice would be empty.
   generate
      if (CONFIG_WIDTH == CHUNK_WIDTH) begin : g_single
         assign w_shifted = i_chunk;
      end else begin : g_multi
         assign w_shifted = {r_shadow[CONFIG_WIDTH-CHUNK_WIDTH-1:0], i_chunk};
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shadow <= '0;
      end else if (i_clear) begin
         r_shadow <= '0;
      end else if (i_enable) begin
         r_shadow <= w_shifted;
      end
   end

   assign o_shadow = r_shadow;
   assign o_chunk  = r_shadow[CONFIG_WIDTH-1 -: CHUNK_WIDTH];

endmodule

// File: rtl/config_frame_loader.sv
// -----------------------------------------------------------------------------
// config_frame_loader
// Daisy-chainable configuration loader for one tile. Chunks shift into a
// shadow register; a commit copies a complete shadow frame into the active
// register in one edge so the fabric never sees partially shifted bits.
//   config_clock  : configuration clock, all state on its rising edge
//   config_nreset : async active-low reset
//   cfg (slave)   : enable/in/commit/clear in; out/data/count/ready/
//                   loaded/error/state out
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module config_frame_loader
   import kfpga_config_pkg::*;
#(
   parameter int CONFIG_WIDTH = CLB_CONFIG_WIDTH,
   parameter int CHUNK_WIDTH  = 1
) (
   input  logic                  config_clock,
   input  logic                  config_nreset,
   config_frame_loader_if.slave  cfg
);

   localparam int FRAMES      = CONFIG_WIDTH / CHUNK_WIDTH;
   localparam int COUNT_WIDTH = clog2(FRAMES + 1);
   localparam logic [COUNT_WIDTH-1:0] FRAMES_C = COUNT_WIDTH'(FRAMES);

   generate
      if ((CONFIG_WIDTH % CHUNK_WIDTH) != 0 || CHUNK_WIDTH < 1) begin : g_bad_width
         $fatal(1, "config_frame_loader: CONFIG_WIDTH must be a multiple of CHUNK_WIDTH");
      end
   endgenerate

   cfg_state_t              r_state;
   cfg_state_t              w_state_nxt;
   logic [COUNT_WIDTH-1:0]  r_count;
   logic [COUNT_WIDTH-1:0]  w_count_nxt;
   logic [CONFIG_WIDTH-1:0] r_data;
   logic                    r_loaded;
   logic                    r_error;
   logic [CONFIG_WIDTH-1:0] w_shadow;
   logic                    w_commit_ok;
   logic                    w_commit_bad;

   config_shift_chain #(
      .CONFIG_WIDTH (CONFIG_WIDTH),
      .CHUNK_WIDTH  (CHUNK_WIDTH)
   ) u_chain (
      .i_clk    (config_clock),
      .i_rst_n  (config_nreset),
      .i_clear  (cfg.config_clear),
      .i_enable (cfg.config_enable),
      .i_chunk  (cfg.config_in),
      .o_shadow (w_shadow),
      .o_chunk  (cfg.config_out)
   );

   // Clear masks a same-cycle commit entirely: no copy and no error.
   assign w_commit_ok  = cfg.config_commit & ~cfg.config_clear & (r_state == ST_FULL);
   assign w_commit_bad = cfg.config_commit & ~cfg.config_clear & (r_state != ST_FULL);

   always_ff @(posedge config_clock or negedge config_nreset) begin
      if (!config_nreset) begin
         r_state <= ST_EMPTY;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      if (cfg.config_clear) begin
         w_state_nxt = ST_EMPTY;
         w_count_nxt = '0;
      end else if (cfg.config_enable) begin
         case (r_state)
            ST_EMPTY, ST_PARTIAL: begin
               w_count_nxt = r_count + COUNT_WIDTH'(1);
               w_state_nxt = (w_count_nxt == FRAMES_C) ? ST_FULL : ST_PARTIAL;
            end
            ST_FULL: begin
               // Pass-through overrun: count saturates, frame stays complete.
               w_count_nxt = FRAMES_C;
               w_state_nxt = ST_FULL;
            end
            default: begin
               w_state_nxt = ST_EMPTY;
               w_count_nxt = '0;
            end
         endcase
      end
   end

   // Active register samples the pre-shift shadow, so a shift in the same
   // cycle as the commit does not leak into the committed frame.
   always_ff @(posedge config_clock or negedge config_nreset) begin
      if (!config_nreset) begin
         r_data   <= '0;
         r_loaded <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         if (w_commit_ok) begin
            r_data   <= w_shadow;
            r_loaded <= 1'b1;
         end
         if (cfg.config_clear) begin
            r_error <= 1'b0;
         end else if (w_commit_bad) begin
            r_error <= 1'b1;
         end
      end
   end

   assign cfg.config_data   = r_data;
   assign cfg.config_count  = r_count;
   assign cfg.config_ready  = (r_state == ST_FULL);
   assign cfg.config_loaded = r_loaded;
   assign cfg.config_error  = r_error;
   assign cfg.config_state  = r_state;

endmodule

// File: tb/tb_config_frame_loader.sv
`timescale 1ns/1ps
module tb_config_frame_loader;

  localparam int CW = 8;
  localparam int CH = 2;
  localparam int FR = CW / CH;

  // clock / reset
  logic clk = 1'b0;
  logic clk_run = 1'b1;
  logic rst_n = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  config_frame_loader_if #(.CONFIG_WIDTH(CW), .CHUNK_WIDTH(CH)) bus ();

  config_frame_loader #(.CONFIG_WIDTH(CW), .CHUNK_WIDTH(CH)) dut (
    .config_clock  (clk),
    .config_nreset (rst_n),
    .cfg           (bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  // reference model: frame as a base-4 number, count of chunks received
  int m_shadow, m_count, m_data;
  bit m_loaded, m_err;
  logic [7:0] prev_data;

  task automatic model_reset();
    m_shadow = 0; m_count = 0; m_data = 0; m_loaded = 0; m_err = 0;
  endtask

  // {data, count, ready, loaded, error, out, shadow}
  function automatic logic [23:0] exp_vec();
    return {8'(m_data), 3'(m_count), (m_count == FR), m_loaded, m_err,
            2'(m_shadow / 64), 8'(m_shadow)};
  endfunction

  function automatic logic [23:0] obs_vec();
    return {bus.config_data, bus.config_count, bus.config_ready, bus.config_loaded,
            bus.config_error, bus.config_out, dut.w_shadow};
  endfunction

  // driver: inputs applied at negedge, model advanced at the edge
  task automatic cycle(input logic en, input logic [1:0] din, input logic cm, input logic cl);
    bus.config_enable = en; bus.config_in = din; bus.config_commit = cm; bus.config_clear = cl;
    @(posedge clk);
    if (cl) begin
      m_shadow = 0; m_count = 0; m_err = 0;
    end else begin
      if (cm) begin
        if (m_count == FR) begin m_data = m_shadow; m_loaded = 1; end
        else m_err = 1;
      end
      if (en) begin
        m_shadow = (m_shadow * 4 + int'(din)) % 256;
        if (m_count < FR) m_count = m_count + 1;
      end
    end
    @(negedge clk);
    bus.config_enable = 0; bus.config_commit = 0; bus.config_clear = 0;
  endtask

  task automatic load_e4();
    cycle(1, 2'b11, 0, 0); cycle(1, 2'b10, 0, 0); cycle(1, 2'b01, 0, 0); cycle(1, 2'b00, 0, 0);
  endtask

  task automatic test_reset();
    n_checks++;
    if (obs_vec() !== 24'h0) begin
      n_fail++; $display("FAIL reset_initial: got %h expected %h", obs_vec(), 24'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    load_e4();
    cycle(0, 0, 1, 0);
    n_checks++;
    if (bus.config_data !== 8'hE4) begin
      n_fail++; $display("FAIL reset_pre_data: got %h expected %h", bus.config_data, 8'hE4);
    end
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_async: got %h expected %h", obs_vec(), exp_vec());
    end
    #20;
    rst_n = 1'b1;
    clk_run = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.config_count, bus.config_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_release: got %b expected %b", {bus.config_count, bus.config_ready}, 4'b0);
    end
  endtask

  task automatic test_load_commit();
    cycle(1, 2'b11, 0, 0); cycle(1, 2'b10, 0, 0); cycle(1, 2'b01, 0, 0);
    n_checks++;
    if (bus.config_ready !== 1'b0 || bus.config_count !== 3'd3) begin
      n_fail++; $display("FAIL load_three: got ready=%b count=%0d expected ready=0 count=3",
                         bus.config_ready, bus.config_count);
    end
    cycle(1, 2'b00, 0, 0);
    n_checks++;
    if ({dut.w_shadow, bus.config_out, bus.config_count, bus.config_ready} !== {8'hE4, 2'b11, 3'd4, 1'b1}) begin
      n_fail++; $display("FAIL load_full: got %h expected %h",
                         {dut.w_shadow, bus.config_out, bus.config_count, bus.config_ready},
                         {8'hE4, 2'b11, 3'd4, 1'b1});
    end
    cycle(0, 0, 1, 0);
    n_checks++;
    if ({bus.config_data, bus.config_loaded} !== {8'hE4, 1'b1}) begin
      n_fail++; $display("FAIL commit: got %h expected %h", {bus.config_data, bus.config_loaded}, {8'hE4, 1'b1});
    end
  endtask

  task automatic test_error_clear();
    cycle(0, 0, 0, 1);
    cycle(1, 2'($urandom_range(0, 3)), 0, 0);
    cycle(1, 2'($urandom_range(0, 3)), 0, 0);
    cycle(0, 0, 1, 0);
    n_checks++;
    if ({bus.config_error, bus.config_data, bus.config_loaded} !== {1'b1, 8'hE4, 1'b1}) begin
      n_fail++; $display("FAIL early_commit: got %h expected %h",
                         {bus.config_error, bus.config_data, bus.config_loaded}, {1'b1, 8'hE4, 1'b1});
    end
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL early_commit_model: got %h expected %h", obs_vec(), exp_vec());
    end
    cycle(0, 0, 0, 1);
    n_checks++;
    if ({bus.config_error, bus.config_count, bus.config_ready, bus.config_data} !== {1'b0, 3'd0, 1'b0, 8'hE4}) begin
      n_fail++; $display("FAIL clear: got %h expected %h",
                         {bus.config_error, bus.config_count, bus.config_ready, bus.config_data},
                         {1'b0, 3'd0, 1'b0, 8'hE4});
    end
  endtask

  task automatic test_overrun();
    cycle(0, 0, 0, 1);
    load_e4();
    n_checks++;
    if (bus.config_out !== 2'b11) begin
      n_fail++; $display("FAIL overrun_pre_out: got %b expected %b", bus.config_out, 2'b11);
    end
    cycle(1, 2'b01, 0, 0);
    n_checks++;
    if ({dut.w_shadow, bus.config_count, bus.config_ready, bus.config_out} !== {8'h91, 3'd4, 1'b1, 2'b10}) begin
      n_fail++; $display("FAIL overrun: got %h expected %h",
                         {dut.w_shadow, bus.config_count, bus.config_ready, bus.config_out},
                         {8'h91, 3'd4, 1'b1, 2'b10});
    end
  endtask

  task automatic test_shift_commit();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < FR; i++) cycle(1, 2'($urandom_range(0, 3)), 0, 0);
    cycle(0, 0, 1, 0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL random_commit: got %h expected %h", obs_vec(), exp_vec());
    end
    cycle(0, 0, 0, 1);
    load_e4();
    cycle(1, 2'b01, 1, 0);
    n_checks++;
    if ({bus.config_data, dut.w_shadow} !== {8'hE4, 8'h91}) begin
      n_fail++; $display("FAIL shift_commit: got %h expected %h", {bus.config_data, dut.w_shadow}, {8'hE4, 8'h91});
    end
  endtask

  task automatic test_clear_commit();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    load_e4();
    prev_data = bus.config_data;
    n_checks++;
    if ({bus.config_error, bus.config_ready} !== 2'b11) begin
      n_fail++; $display("FAIL clear_commit_setup: got %b expected %b", {bus.config_error, bus.config_ready}, 2'b11);
    end
    cycle(0, 0, 1, 1);
    n_checks++;
    if ({bus.config_count, bus.config_error, bus.config_ready, bus.config_data} !== {3'd0, 1'b0, 1'b0, 8'hE4}) begin
      n_fail++; $display("FAIL clear_commit: got %h expected %h",
                         {bus.config_count, bus.config_error, bus.config_ready, bus.config_data},
                         {3'd0, 1'b0, 1'b0, 8'hE4});
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0));
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        if (errs < 10) $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
        errs++;
      end
    end
  endtask

  initial begin
    bus.config_enable = 0; bus.config_in = 0; bus.config_commit = 0; bus.config_clear = 0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_load_commit();
    test_error_clear();
    test_overrun();
    test_shift_commit();
    test_clear_commit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
